// File: rtl/sc_statemachine_loadmulti_if.sv
// Control bus between the game-level start/flag logic and the background
// register sequencer. Clock and reset are plain ports on the sequencer.
//
// Request semantics: a FLAG bit held low is a level request for its lane.
// It is sampled only while the sequencer sits in CHECK. There is no separate
// ready signal: the one-cycle low pulse on load_OutLow[lane] is the
// acknowledgement. The requester keeps its bit low until it has seen that
// pulse; a bit dropped early is simply never served.
interface sc_statemachine_loadmulti_if #(
  parameter int NUM_CH        = 4,
  parameter int LOADCNT_WIDTH = 8
);
  logic                     SC_STATEMACHINEBACKG_startButton_InLow;
  logic [NUM_CH-1:0]        SC_STATEMACHINEBACKG_FLAG_InLow;
  logic                     SC_STATEMACHINEBACKG_pause_InHigh;
  logic                     SC_STATEMACHINEBACKG_reset_OutHigh;
  logic                     SC_STATEMACHINEBACKG_CLEAR_OutHigh;
  logic [NUM_CH-1:0]        SC_STATEMACHINEBACKG_load_OutLow;
  logic                     SC_STATEMACHINEBACKG_upcount_OutLow;
  logic [2:0]               SC_STATEMACHINEBACKG_state_Out;
  logic [LOADCNT_WIDTH-1:0] SC_STATEMACHINEBACKG_loadcount_Out;

  // Requester side: drives start/flags/pause and watches the strobes.
  modport master (
    output SC_STATEMACHINEBACKG_startButton_InLow,
    output SC_STATEMACHINEBACKG_FLAG_InLow,
    output SC_STATEMACHINEBACKG_pause_InHigh,
    input  SC_STATEMACHINEBACKG_reset_OutHigh,
    input  SC_STATEMACHINEBACKG_CLEAR_OutHigh,
    input  SC_STATEMACHINEBACKG_load_OutLow,
    input  SC_STATEMACHINEBACKG_upcount_OutLow,
    input  SC_STATEMACHINEBACKG_state_Out,
    input  SC_STATEMACHINEBACKG_loadcount_Out
  );

  // Sequencer side.
  modport slave (
    input  SC_STATEMACHINEBACKG_startButton_InLow,
    input  SC_STATEMACHINEBACKG_FLAG_InLow,
    input  SC_STATEMACHINEBACKG_pause_InHigh,
    output SC_STATEMACHINEBACKG_reset_OutHigh,
    output SC_STATEMACHINEBACKG_CLEAR_OutHigh,
    output SC_STATEMACHINEBACKG_load_OutLow,
    output SC_STATEMACHINEBACKG_upcount_OutLow,
    output SC_STATEMACHINEBACKG_state_Out,
    output SC_STATEMACHINEBACKG_loadcount_Out
  );
endinterface

// File: rtl/sc_statemachine_loadmulti.sv
// Multi-lane background register sequencer: round-robin load arbitration,
// tick prescaler pacing the count pulses, pause, saturating load counter.
// Optional macro SC_STATEMACHINELOADMULTI_INSYNC_EN adds 2-flop input
// synchronizers (reset value 1) on start and FLAG.
module sc_statemachine_loadmulti #(
  parameter int NUM_CH        = 4,
  parameter int TICK_WIDTH    = 20,
  parameter int TICK_DIV      = 1000000,
  parameter int LOADCNT_WIDTH = 8
) (
  input logic                       SC_STATEMACHINEBACKG_CLOCK_50,
  input logic                       SC_STATEMACHINEBACKG_RESET_InHigh,
  sc_statemachine_loadmulti_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_START = 3'd1,
    ST_CHECK = 3'd2,
    ST_INIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_LOAD  = 3'd5,
    ST_COUNT = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [TICK_WIDTH-1:0]    presc_q;
  logic                     tick_pend_q;
  logic [SEL_W-1:0]         sel_q, rr_q;
  logic [LOADCNT_WIDTH-1:0] loadcount_q;

  logic                     start_n;
  logic [NUM_CH-1:0]        flag_n;
  logic                     pause;

  logic [SEL_W-1:0]         pick;
  logic [SEL_W-1:0]         pick_next;
  logic                     any_req;
  logic                     serve;
  logic                     counting;
  logic                     wrap;

  assign pause = bus.SC_STATEMACHINEBACKG_pause_InHigh;

`ifdef SC_STATEMACHINELOADMULTI_INSYNC_EN
  logic [1:0]        start_sync;
  logic [NUM_CH-1:0] flag_s1, flag_s2;

  // Two-flop synchronizers; idle-high reset so nothing looks requested.
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      start_sync <= 2'b11;
      flag_s1    <= '1;
      flag_s2    <= '1;
    end else begin
      start_sync <= {start_sync[0], bus.SC_STATEMACHINEBACKG_startButton_InLow};
      flag_s1    <= bus.SC_STATEMACHINEBACKG_FLAG_InLow;
      flag_s2    <= flag_s1;
    end
  end

  assign start_n = start_sync[1];
  assign flag_n  = flag_s2;
`else
  assign start_n = bus.SC_STATEMACHINEBACKG_startButton_InLow;
  assign flag_n  = bus.SC_STATEMACHINEBACKG_FLAG_InLow;
`endif

  assign any_req  = ~&flag_n;
  // A pending tick is taken by CHECK only when start is idle and not paused.
  assign serve    = (state_q == ST_CHECK) && start_n && tick_pend_q && !pause;
  assign counting = ((state_q == ST_CHECK) || (state_q == ST_LOAD) ||
                     (state_q == ST_COUNT)) && !pause;
  assign wrap     = counting && (presc_q == TICK_LAST);
  assign pick_next = (int'(pick) == NUM_CH - 1) ? '0 : pick + 1'b1;

  // Round-robin pick: first low FLAG bit at or above rr, wrapping.
  always_comb begin
    logic found;
    pick  = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !flag_n[(int'(rr_q) + i) % NUM_CH]) begin
        pick  = SEL_W'((int'(rr_q) + i) % NUM_CH);
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) state_q <= ST_RESET;
    else                                   state_q <= state_d;
  end

  // Next-state decode; start outranks any pending tick in CHECK.
  always_comb begin
    state_d = ST_CHECK;
    case (state_q)
      ST_RESET: state_d = ST_START;
      ST_START: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!start_n)                     state_d = ST_INIT;
        else if (tick_pend_q && !pause)   state_d = any_req ? ST_LOAD : ST_COUNT;
        else                              state_d = ST_CHECK;
      end
      ST_INIT:  state_d = ST_HOLD;
      ST_HOLD:  state_d = start_n ? ST_CHECK : ST_HOLD;
      ST_LOAD:  state_d = ST_COUNT;
      ST_COUNT: state_d = ST_CHECK;
      default:  state_d = ST_CHECK;
    endcase
  end

  // Prescaler, tick latch, lane pointers and load counter.
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      sel_q       <= '0;
      rr_q        <= '0;
      loadcount_q <= '0;
    end else if (state_q == ST_INIT) begin
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      rr_q        <= '0;
      loadcount_q <= '0;
    end else begin
      if (counting) presc_q <= wrap ? '0 : presc_q + 1'b1;
      // A tick landing on an already pending one is dropped, not queued.
      tick_pend_q <= wrap | (tick_pend_q & ~serve);
      if (serve && any_req) begin
        sel_q <= pick;
        rr_q  <= pick_next;
      end
      if ((state_q == ST_LOAD) && (loadcount_q != '1)) loadcount_q <= loadcount_q + 1'b1;
    end
  end

  // Moore output decode from state and latched lane.
  always_comb begin
    bus.SC_STATEMACHINEBACKG_reset_OutHigh  = 1'b0;
    bus.SC_STATEMACHINEBACKG_CLEAR_OutHigh  = 1'b0;
    bus.SC_STATEMACHINEBACKG_load_OutLow    = '1;
    bus.SC_STATEMACHINEBACKG_upcount_OutLow = 1'b1;
    case (state_q)
      ST_RESET: bus.SC_STATEMACHINEBACKG_CLEAR_OutHigh = 1'b1;
      ST_INIT: begin
        bus.SC_STATEMACHINEBACKG_reset_OutHigh = 1'b1;
        bus.SC_STATEMACHINEBACKG_CLEAR_OutHigh = 1'b1;
      end
      ST_LOAD: begin
        bus.SC_STATEMACHINEBACKG_reset_OutHigh      = 1'b1;
        bus.SC_STATEMACHINEBACKG_load_OutLow[sel_q] = 1'b0;
      end
      ST_COUNT: bus.SC_STATEMACHINEBACKG_upcount_OutLow = 1'b0;
      default: ;
    endcase
  end

  assign bus.SC_STATEMACHINEBACKG_state_Out     = state_q;
  assign bus.SC_STATEMACHINEBACKG_loadcount_Out = loadcount_q;
endmodule

// File: doc/sc_statemachine_loadmulti.md
Name: sc_statemachine_loadmulti

Overview:
Parametrised multi-channel sequencer for background shift registers. It replaces single-channel load/count control with N independently requested load lanes, round-robin arbitration, and a programmable tick prescaler that paces the count pulses. It also adds pause, a saturating load-event counter and a state debug output. It sits between the game-level start/flag logic and the bank of background registers.

Parameters:
NUM_CH, 4, number of load channels (2..8)
TICK_WIDTH, 20, prescaler counter width
TICK_DIV, 1000000, clocks per tick (2..2^TICK_WIDTH)
LOADCNT_WIDTH, 8, width of load-event counter

Ports:
SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock
SC_STATEMACHINEBACKG_RESET_InHigh  in  1  reset, asynchronous, active-high
SC_STATEMACHINEBACKG_startButton_InLow  in  1  start request, active-low level
SC_STATEMACHINEBACKG_FLAG_InLow  in  NUM_CH  per-channel load request, active-low
SC_STATEMACHINEBACKG_pause_InHigh  in  1  freeze prescaler and pacing
SC_STATEMACHINEBACKG_reset_OutHigh  out  1  register reset strobe
SC_STATEMACHINEBACKG_CLEAR_OutHigh  out  1  register clear strobe
SC_STATEMACHINEBACKG_load_OutLow  out  NUM_CH  per-channel load, active-low, at most one low
SC_STATEMACHINEBACKG_upcount_OutLow  out  1  shift/count pulse, active-low
SC_STATEMACHINEBACKG_state_Out  out  3  current state encoding
SC_STATEMACHINEBACKG_loadcount_Out  out  LOADCNT_WIDTH  load events since INIT

Behaviour:
- Moore FSM. Outputs are decoded combinationally from the state register plus the latched channel index `sel`. State encoding: RESET=0, START=1, CHECK=2, INIT=3, HOLD=4, LOAD=5, COUNT=6. Illegal codes go to CHECK with idle outputs.
- Async reset puts the FSM in RESET and clears the prescaler, tick_pend, sel, rr pointer and loadcount to 0. This applies mid-operation too.
- Outputs in RESET: reset_OutHigh=0, CLEAR=1, load all 1, upcount=1, state=0.
- Idle outputs (START, CHECK, HOLD): reset=0, CLEAR=0, load all 1, upcount=1.
- RESET -> START -> CHECK, one cycle each.
- Prescaler:
  - Counts only in CHECK, LOAD and COUNT, and only while pause=0.
  - At TICK_DIV-1 it wraps to 0 and sets tick_pend.
  - tick_pend is cleared when CHECK consumes it. A tick arriving while tick_pend=1 is dropped (no accumulation).
- CHECK, in priority order:
  - start=0 -> INIT.
  - Else tick_pend=1 and pause=0 and any FLAG bit=0 -> LOAD. Latch sel = first low FLAG bit searching upward from rr (wrapping); then rr <= sel+1 mod NUM_CH.
  - Else tick_pend=1 and pause=0 -> COUNT.
  - Else stay in CHECK.
- INIT (1 cycle): reset=1, CLEAR=1, load all 1, upcount=1. Clears loadcount, prescaler, tick_pend and rr. -> HOLD.
- HOLD: stay while start=0; start=1 -> CHECK. Prevents retrigger on a held button.
- LOAD (1 cycle): reset=1, CLEAR=0, load[sel]=0 with all other bits 1, upcount=1. loadcount increments, saturating at all-ones. -> COUNT.
- COUNT (1 cycle): upcount=0, everything else idle. -> CHECK.
- Minimum tick-to-pulse latency: tick_pend set at cycle t, CHECK at t+1 (if already there), LOAD/COUNT at t+2. A FLAG bit is sampled only in CHECK; changes at any other time are ignored.
- Start during LOAD/COUNT takes effect at the next CHECK. Pause has no effect on start.

Optional Feature:
Macro SC_STATEMACHINELOADMULTI_INSYNC_EN.
- Defined: start and FLAG each pass through a 2-flop synchronizer (reset value 1) before FSM use. This adds exactly 2 cycles of input latency.
- Undefined: inputs are used directly and must already be synchronous to the clock.

Test Plan:
- Bench parameters: NUM_CH=4, TICK_DIV=4, sync undefined.
- Reset 3 cycles, release, all inputs high -> state 0,1,2; COUNT pulse (upcount=0) every 4 cycles; load stays 4'b1111; loadcount=0.
- FLAG=4'b1010 held -> successive LOAD pulses select ch0, ch2, ch0 (load=4'b1110, 4'b1011, 4'b1110), each followed by one upcount=0 cycle; loadcount 1,2,3.
- start=0 held 10 cycles in CHECK -> INIT one cycle (reset=1, CLEAR=1); HOLD for the remainder with no pulses; loadcount=0; after release, first COUNT comes 4+ cycles later.
- pause=1 for 20 cycles -> no load/upcount pulses and prescaler frozen; after pause=0, pulse resumes within remaining tick count.
- Async reset asserted mid-LOAD -> outputs immediately take RESET values (CLEAR=1, load=4'b1111); loadcount=0.
- loadcount saturation (LOADCNT_WIDTH=2) -> value holds at 3 after a 5th load.
